// File: rtl/shared_resource_unit.sv
// Two-stage (data * MUL_K + ADD_K) compute stage with an output FIFO.
// The FIFO slack lets out_stall come straight from a flop.
module shared_resource_unit #(
    parameter logic [31:0] MUL_K = 32'd3,
    parameter logic [31:0] ADD_K = 32'd5,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_flush,
    input  logic        in_stall,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_flush,
    output logic        out_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          s1_valid_q, s1_valid_d;
    logic [31:0]   s1_prod_q, s1_prod_d;
    logic          s2_valid_q, s2_valid_d;
    logic [31:0]   s2_sum_q, s2_sum_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          flush_q, flush_d;
    logic [31:0]   mem_q [DEPTH];

    logic adv;
    logic push;
    logic pop;

    always_comb begin
        adv  = !stall_q;
        push = adv && s2_valid_q;
        pop  = (count_q != '0) && !in_stall;

        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_prod_d  = in_data * MUL_K;
            s2_valid_d = s1_valid_q;
            s2_sum_d   = s1_prod_q + ADD_K;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        // Stall one entry early so nothing pushed after the stall decision can overflow.
        stall_d  = (count_d >= CW'(DEPTH - 1));
        flush_d  = 1'b0;

        if (in_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            stall_d    = 1'b0;
            flush_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !in_flush && !reset) begin
            mem_q[wr_ptr_q] <= s2_sum_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign out_stall = stall_q;
    assign out_flush = flush_q;
endmodule
